// File: rtl/aoi_pkg.sv
// aoi_pkg: shared definitions for the AOI sweep sequencer.
//   - 2-bit FSM state encoding and the matching enum type
//   - NUM_VEC: number of input combinations of the 4-input datapath
//   - bit positions of a/b/c/d inside vec_out and e/f/g inside res_in
package aoi_pkg;

  localparam int NUM_VEC = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_DRIVE  = ST_DRIVE,
    S_SAMPLE = ST_SAMPLE,
    S_DONE   = ST_DONE
  } state_t;

  // Datapath input bit positions: {a,b,c,d} = vec[3:0]
  localparam int VEC_A = 3;
  localparam int VEC_B = 2;
  localparam int VEC_C = 1;
  localparam int VEC_D = 0;

  // Datapath result bit positions: {e,f,g} = res[2:0]
  localparam int RES_E = 2;
  localparam int RES_F = 1;
  localparam int RES_G = 0;

endpackage

// File: rtl/aoi4_expect.sv
// aoi4_expect: combinational expected-value generator for the AOI datapath.
// Ports:
//   vec  in  4  {a,b,c,d}
//   res  out 3  {e,f,g} with e = a&b, f = a&b&c, g = ~(e|f); d is ignored
module aoi4_expect
  import aoi_pkg::*;
(
  input  logic [3:0] vec,
  output logic [2:0] res
);

  logic e;
  logic f;
  logic unused_d;

  // d does not participate in the function
  assign unused_d = vec[VEC_D];

  // Golden AND-OR-INVERT function
  always_comb begin
    e = vec[VEC_A] & vec[VEC_B];
    f = e & vec[VEC_C];
    res = 3'b000;
    res[RES_E] = e;
    res[RES_F] = f;
    res[RES_G] = ~(e | f);
  end

endmodule

// File: rtl/aoi_sweep_ctrl.sv
// aoi_sweep_ctrl: drives all 16 vectors onto the AOI datapath, waits SETTLE
// cycles per vector, samples and checks the result, and keeps error records.
// Parameters:
//   SETTLE           DRIVE cycles per vector before sampling (>= 1)
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start, abort     level controls (start only honoured in IDLE without abort)
//   vec_out          datapath drive {a,b,c,d}
//   res_in           datapath result {e,f,g}, sampled in SAMPLE
//   busy, done       busy in DRIVE/SAMPLE, one-cycle done pulse
//   pass             last completed sweep had zero mismatches
//   err_cnt          mismatching vectors in current/last sweep
//   first_err_vec    index of first mismatch, qualified by first_err_valid
module aoi_sweep_ctrl
  import aoi_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] vec_out,
  input  logic [2:0] res_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_err_vec,
  output logic       first_err_valid
);

  localparam int            CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [3:0]    LAST_VEC    = 4'(NUM_VEC - 1);

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic [2:0]    exp_res;
  logic          mismatch;

  aoi4_expect u_expect (
    .vec (vec_out),
    .res (exp_res)
  );

  assign mismatch = (res_in != exp_res);

  // Sweep FSM with settle/vector counters, error bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      settle_cnt      <= '0;
      vec_out         <= 4'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= 5'd0;
      first_err_vec   <= 4'd0;
      first_err_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state           <= S_DRIVE;
            busy            <= 1'b1;
            vec_out         <= 4'd0;
            err_cnt         <= 5'd0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            settle_cnt      <= '0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        S_SAMPLE: begin
          // The comparison is recorded even when abort arrives in this cycle
          if (mismatch) begin
            err_cnt <= err_cnt + 5'd1;
            if (!first_err_valid) begin
              first_err_vec   <= vec_out;
              first_err_valid <= 1'b1;
            end
          end
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (vec_out == LAST_VEC) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Final verdict includes the mismatch found in this last sample
            pass  <= (err_cnt == 5'd0) && !mismatch;
          end else begin
            state      <= S_DRIVE;
            vec_out    <= vec_out + 4'd1;
            settle_cnt <= '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aoi_sweep_ctrl.sv
// tb_aoi_sweep_ctrl: self-checking bench for aoi_sweep_ctrl. Two instances
// (SETTLE=1 and SETTLE=3) each see a behavioural datapath whose result can be
// corrupted per vector through a flip table; expectations come from counting
// corrupted vectors and from the cycle-window arithmetic of the sweep.
module tb_aoi_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a [2];
  logic       abort_a [2];
  logic [2:0] res_a   [2];
  logic [3:0] vec_a   [2];
  logic [3:0] fev_a   [2];
  logic       busy_a  [2];
  logic       done_a  [2];
  logic       pass_a  [2];
  logic       fval_a  [2];
  logic [4:0] err_a   [2];
  logic [2:0] flip    [2][16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aoi_sweep_ctrl #(.SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start_a[0]), .abort(abort_a[0]),
    .vec_out(vec_a[0]), .res_in(res_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .pass(pass_a[0]), .err_cnt(err_a[0]), .first_err_vec(fev_a[0]),
    .first_err_valid(fval_a[0])
  );

  aoi_sweep_ctrl #(.SETTLE(3)) dut_s3 (
    .clk(clk), .rst(rst), .start(start_a[1]), .abort(abort_a[1]),
    .vec_out(vec_a[1]), .res_in(res_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .pass(pass_a[1]), .err_cnt(err_a[1]), .first_err_vec(fev_a[1]),
    .first_err_valid(fval_a[1])
  );

  // Ideal AOI written arithmetically: a&b <=> v >= 12, a&b&c <=> v >= 14
  function automatic logic [2:0] golden(input logic [3:0] v);
    logic e, f, g;
    e = (v >= 4'd12);
    f = (v >= 4'd14);
    g = (v < 4'd12);
    return {e, f, g};
  endfunction

  // Behavioural datapath with per-vector fault injection
  always_comb begin
    res_a[0] = golden(vec_a[0]) ^ flip[0][vec_a[0]];
    res_a[1] = golden(vec_a[1]) ^ flip[1][vec_a[1]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int sel);
    check_val("rst_busy", 32'(busy_a[sel]), 32'd0);
    check_val("rst_done", 32'(done_a[sel]), 32'd0);
    check_val("rst_pass", 32'(pass_a[sel]), 32'd0);
    check_val("rst_vec",  32'(vec_a[sel]),  32'd0);
    check_val("rst_err",  32'(err_a[sel]),  32'd0);
    check_val("rst_fev",  32'(fev_a[sel]),  32'd0);
    check_val("rst_fval", 32'(fval_a[sel]), 32'd0);
  endtask

  task automatic set_flips(input int sel, input int mode);
    for (int v = 0; v < 16; v++) begin
      case (mode)
        1:       flip[sel][v] = (v < 12) ? 3'b001 : 3'b000;   // g stuck at 0
        2:       flip[sel][v] = (v < 14) ? 3'b010 : 3'b000;   // f stuck at 1
        3:       flip[sel][v] = (v == 15) ? 3'b010 : 3'b000;  // f forced 0 on last vector
        4:       flip[sel][v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        default: flip[sel][v] = 3'b000;
      endcase
    end
  endtask

  // One sweep from a start pulse at cycle 0; abort_at < 0 means no abort
  task automatic run_sweep(input int sel, input int abort_at);
    int s, win, len, last, nvec, exp_err, exp_first, k;
    logic exp_busy, exp_done;
    s = (sel == 1) ? 3 : 1;
    win = s + 1;
    len = 16 * win;
    k = 15;
    nvec = 16;
    if (abort_at >= 0) begin
      k = (abort_at - 1) / win;
      nvec = k + ((((abort_at - 1) % win) == s) ? 1 : 0);
    end
    exp_err = 0;
    exp_first = -1;
    for (int v = 0; v < nvec; v++) begin
      if (flip[sel][v] != 3'b000) begin
        exp_err++;
        if (exp_first < 0) exp_first = v;
      end
    end
    last = (abort_at < 0) ? len + 1 : abort_at + 1;

    start_a[sel] = 1'b1;
    step();
    start_a[sel] = 1'b0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      exp_busy = (cyc <= len) && (abort_at < 0 || cyc <= abort_at);
      exp_done = (abort_at < 0) && (cyc == len + 1);
      check_val("busy", 32'(busy_a[sel]), 32'(exp_busy));
      check_val("done", 32'(done_a[sel]), 32'(exp_done));
      if (exp_busy) check_val("vec", 32'(vec_a[sel]), 32'((cyc - 1) / win));
      if (cyc == abort_at) abort_a[sel] = 1'b1;
      step();
      abort_a[sel] = 1'b0;
    end
    check_val("end_busy", 32'(busy_a[sel]), 32'd0);
    check_val("end_done", 32'(done_a[sel]), 32'd0);
    check_val("err_cnt",  32'(err_a[sel]),  32'(exp_err));
    check_val("pass",     32'(pass_a[sel]), 32'((abort_at < 0) && (exp_err == 0)));
    check_val("fval",     32'(fval_a[sel]), 32'(exp_first >= 0));
    if (exp_first >= 0) check_val("fev", 32'(fev_a[sel]), 32'(exp_first));
    if (abort_at >= 0) check_val("abort_vec", 32'(vec_a[sel]), 32'(k));
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0;
      abort_a[i] = 1'b0;
      set_flips(i, 0);
    end
    step();
    step();
    rst = 1'b0;
    check_reset(0);
    check_reset(1);

    // Directed sweeps on SETTLE=1
    run_sweep(0, -1);
    set_flips(0, 1); run_sweep(0, -1);
    set_flips(0, 2); run_sweep(0, -1);
    set_flips(0, 3); run_sweep(0, -1);

    // SETTLE=3: full sweep, then abort at cycle 10 after a passing sweep
    run_sweep(1, -1);
    run_sweep(1, 10);

    // Start together with abort in IDLE must not launch a sweep
    start_a[0] = 1'b1;
    abort_a[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("start_abort_idle", 32'(busy_a[0]), 32'd0);
    end
    start_a[0] = 1'b0;
    abort_a[0] = 1'b0;

    // Start held high: done at 33, then a new sweep is running at cycle 35
    set_flips(0, 0);
    start_a[0] = 1'b1;
    for (int cyc = 1; cyc <= 35; cyc++) begin
      step();
      if (cyc == 33) check_val("held_done", 32'(done_a[0]), 32'd1);
      if (cyc == 34) check_val("held_idle", 32'(busy_a[0]), 32'd0);
    end
    check_val("held_restart", 32'(busy_a[0]), 32'd1);
    start_a[0] = 1'b0;
    abort_a[0] = 1'b1;
    step();
    abort_a[0] = 1'b0;
    step();

    // Reset asserted at cycle 20 of a failing sweep
    set_flips(0, 1);
    start_a[0] = 1'b1;
    step();
    start_a[0] = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) step();
    check_val("pre_rst_err", 32'(err_a[0] != 5'd0), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset(0);
    check_reset(1);

    // Randomized fault tables, instance choice and abort points
    for (int n = 0; n < 12; n++) begin
      int sel, ab;
      sel = int'($urandom_range(0, 1));
      set_flips(sel, 4);
      if ($urandom_range(0, 1) == 1)
        ab = int'($urandom_range(1, (sel == 1) ? 64 : 32));
      else
        ab = -1;
      run_sweep(sel, ab);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
